// File: rtl/ws2812b_meter_pkg.sv
// Shared types and constants for the WS2812B meter scheduler.
// Colors are GRB words; reset-gap timing is shared with the serializer.
package ws2812b_meter_pkg;

    typedef logic [23:0] grb_t;

    localparam grb_t COLOR_OFF = 24'h000000;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        LOAD,
        STREAM,
        LATCH
    } sched_state_t;

    // WS2812B latch needs a low gap longer than 50 us
    localparam int unsigned RESET_GAP_US         = 50;
    localparam int unsigned RESET_GAP_CYC_100MHZ = 5000;

    // Zone color for a lit pixel; an inverted limit pair empties zone 1
    function automatic grb_t zone_color(
        input logic [15:0] idx,
        input logic [15:0] lim0,
        input logic [15:0] lim1,
        input grb_t        c0,
        input grb_t        c1,
        input grb_t        c2
    );
        if (idx < lim0)
            return c0;
        else if (idx < lim1)
            return c1;
        else
            return c2;
    endfunction

endpackage

// File: rtl/ws2812b_meter_peak_hold.sv
// Peak marker position with hold-then-decay behaviour.
// Updates once per frame on the load strobe, clamped to the strip length.
module ws2812b_peak_hold (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [15:0] i_on,
    input  logic [15:0] i_n,
    input  logic [7:0]  i_hold_frames,
    output logic [15:0] o_peak
);

    logic [15:0] r_peak;
    logic [7:0]  r_hold;
    logic [15:0] w_peak_raw;
    logic [15:0] w_peak_next;
    logic [7:0]  w_hold_next;

    // Next peak/hold: rise immediately, otherwise hold, then decay by one
    always_comb begin
        w_peak_raw  = r_peak;
        w_hold_next = r_hold;
        if (i_on >= r_peak) begin
            w_peak_raw  = i_on;
            w_hold_next = i_hold_frames;
        end else if (r_hold != 8'd0) begin
            w_hold_next = r_hold - 8'd1;
        end else if (r_peak != 16'd0) begin
            w_peak_raw  = r_peak - 16'd1;
        end
        w_peak_next = (w_peak_raw > i_n) ? i_n : w_peak_raw;
    end

    // Peak/hold registers, advanced once per frame load
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_peak <= 16'd0;
            r_hold <= 8'd0;
        end else if (i_load) begin
            r_peak <= w_peak_next;
            r_hold <= w_hold_next;
        end
    end

    assign o_peak = r_peak;

endmodule

// File: rtl/ws2812b_meter_scheduler.sv
// Frame scheduler in front of the WS2812B serializer: per-tick frame of
// led_count GRB words over valid/ready, then a latch request.
module ws2812b_meter_scheduler
    import ws2812b_meter_pkg::*;
#(
    parameter int unsigned FRAME_TICKS = 1666667,
    parameter logic [23:0] PEAK_COLOR  = 24'hFFFFFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_level_valid,
    output logic        o_level_ready,
    input  logic [15:0] i_level,
    input  logic [15:0] i_led_count,
    input  logic [15:0] i_zone_limit0,
    input  logic [15:0] i_zone_limit1,
    input  logic [23:0] i_color0,
    input  logic [23:0] i_color1,
    input  logic [23:0] i_color2,
    input  logic [7:0]  i_peak_hold_frames,
    output logic        o_pixel_valid,
    input  logic        i_pixel_ready,
    output logic [23:0] o_pixel_color,
    output logic        o_pixel_last,
    output logic        o_latch_req,
    input  logic        i_latch_done,
    output logic        o_frame_busy,
    output logic        o_frame_overrun,
    output logic [15:0] o_on_count,
    output logic [15:0] o_peak_pos
);

    localparam logic [23:0] TICK_LAST = 24'(FRAME_TICKS - 1);

    sched_state_t r_state;
    sched_state_t w_state_next;

    logic [23:0] r_tick_cnt;
    logic [15:0] r_level;
    logic [15:0] r_n;
    logic [15:0] r_on;
    logic [15:0] r_idx;

    logic        w_tick;
    logic        w_load;
    logic        w_hs;
    logic        w_last;
    logic [15:0] w_on;
    logic [15:0] w_peak;
    grb_t        w_color;

    assign w_tick = (r_tick_cnt == TICK_LAST);
    assign w_load = (r_state == LOAD);
    assign w_on   = (r_level < i_led_count) ? r_level : i_led_count;
    assign w_last = (r_idx == r_n - 16'd1);
    assign w_hs   = o_pixel_valid && i_pixel_ready;

    // Free-running frame period counter, independent of state
    always_ff @(posedge i_clk) begin
        if (i_reset || w_tick)
            r_tick_cnt <= 24'd0;
        else
            r_tick_cnt <= r_tick_cnt + 24'd1;
    end

    // Newest level sample wins and is held until replaced
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_level <= 16'd0;
        else if (i_level_valid)
            r_level <= i_level;
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic for the frame sequence
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:   if (i_enable) w_state_next = WAIT;
            WAIT: begin
                if (w_tick && i_enable)
                    w_state_next = LOAD;
                else if (!i_enable)
                    w_state_next = IDLE;
            end
            LOAD: begin
                if (i_led_count == 16'd0)
                    w_state_next = WAIT;
                else
                    w_state_next = STREAM;
            end
            STREAM: if (w_hs && w_last) w_state_next = LATCH;
            LATCH:  if (i_latch_done) w_state_next = WAIT;
            default: w_state_next = IDLE;
        endcase
    end

    // Frame snapshot at LOAD and pixel index advance on handshake
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_n   <= 16'd0;
            r_on  <= 16'd0;
            r_idx <= 16'd0;
        end else if (w_load) begin
            r_n   <= i_led_count;
            r_on  <= w_on;
            r_idx <= 16'd0;
        end else if (w_hs && !w_last) begin
            r_idx <= r_idx + 16'd1;
        end
    end

    ws2812b_peak_hold u_peak (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_load        (w_load),
        .i_on          (w_on),
        .i_n           (i_led_count),
        .i_hold_frames (i_peak_hold_frames),
        .o_peak        (w_peak)
    );

    // Pixel color: lit zone, then peak marker above the lit bar, else off
    always_comb begin
        w_color = COLOR_OFF;
        if (r_idx < r_on)
            w_color = zone_color(r_idx, i_zone_limit0, i_zone_limit1,
                                 i_color0, i_color1, i_color2);
        else if (w_peak > r_on && r_idx == w_peak - 16'd1)
            w_color = PEAK_COLOR;
    end

    assign o_level_ready   = !i_reset;
    assign o_pixel_valid   = (r_state == STREAM);
    assign o_pixel_color   = o_pixel_valid ? w_color : COLOR_OFF;
    assign o_pixel_last    = o_pixel_valid && w_last;
    assign o_latch_req     = (r_state == LATCH);
    assign o_frame_busy    = (r_state == LOAD) || (r_state == STREAM) ||
                             (r_state == LATCH);
    assign o_frame_overrun = w_tick && o_frame_busy;
    assign o_on_count      = r_on;
    assign o_peak_pos      = w_peak;

endmodule

// File: tb/tb_ws2812b_meter_scheduler.sv
// Self-checking bench for ws2812b_meter_scheduler: table vectors,
// corner sequences and randomized frames against a frame-level model.
module tb_ws2812b_meter_scheduler;
    import ws2812b_meter_pkg::*;

    localparam int FT = 64;
    localparam logic [23:0] PK = 24'hFFFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        level_valid = 1'b0;
    logic        pixel_ready = 1'b0;
    logic        latch_done = 1'b0;
    logic [15:0] level = '0, led_count = '0, zl0 = '0, zl1 = '0;
    logic [23:0] c0 = '0, c1 = '0, c2 = '0;
    logic [7:0]  hold_fr = '0;

    logic        level_ready, pixel_valid, pixel_last;
    logic        latch_req, frame_busy, frame_overrun;
    logic [23:0] pixel_color;
    logic [15:0] on_count, peak_pos;

    ws2812b_meter_scheduler #(.FRAME_TICKS(FT), .PEAK_COLOR(PK)) dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable),
        .i_level_valid(level_valid), .o_level_ready(level_ready),
        .i_level(level), .i_led_count(led_count),
        .i_zone_limit0(zl0), .i_zone_limit1(zl1),
        .i_color0(c0), .i_color1(c1), .i_color2(c2),
        .i_peak_hold_frames(hold_fr),
        .o_pixel_valid(pixel_valid), .i_pixel_ready(pixel_ready),
        .o_pixel_color(pixel_color), .o_pixel_last(pixel_last),
        .o_latch_req(latch_req), .i_latch_done(latch_done),
        .o_frame_busy(frame_busy), .o_frame_overrun(frame_overrun),
        .o_on_count(on_count), .o_peak_pos(peak_pos)
    );

    always #5 clk = ~clk;

    // cycle index since reset release; tick cycles have index % FT == FT-1
    int kcyc = 0;
    always @(posedge clk) kcyc <= reset ? 0 : kcyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // frame-level reference model
    int   m_level = 0, m_peak = 0, m_hold = 0, m_on = 0;
    grb_t exp_q[$];
    int   g_p, g_t;

    task automatic model_frame(input int n, z0, z1, hf,
                               input grb_t a, b, cc);
        m_on = (m_level < n) ? m_level : n;
        if (m_on >= m_peak) begin
            m_peak = m_on;
            m_hold = hf;
        end else if (m_hold > 0) m_hold--;
        else if (m_peak > 0) m_peak--;
        if (m_peak > n) m_peak = n;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            if (i < m_on) exp_q.push_back(i < z0 ? a : (i < z1 ? b : cc));
            else if (m_peak > m_on && i == m_peak - 1) exp_q.push_back(PK);
            else exp_q.push_back(24'h0);
        end
    endtask

    // drive new frame inputs while the DUT waits, clear of the tick
    task automatic apply(input int lvl, n, z0, z1, hf,
                         input grb_t a, b, cc);
        while (kcyc % FT >= FT - 3) @(negedge clk);
        level = 16'(lvl); led_count = 16'(n);
        zl0 = 16'(z0); zl1 = 16'(z1); hold_fr = 8'(hf);
        c0 = a; c1 = b; c2 = cc;
        level_valid = 1'b1;
        @(negedge clk);
        level_valid = 1'b0;
        m_level = lvl;
    endtask

    task automatic run_frame(input int mode, input int ld);
        grb_t got_c[$];
        logic got_l[$];
        int   waited = 0, cyc = 0, bad_st = 0, bad_l = 0;
        logic stalled = 0, done = 0, sl = 0;
        grb_t sc = '0;
        g_p = 0; g_t = 0;
        while (!pixel_valid && waited < 200) begin
            @(negedge clk); waited++;
        end
        if (!pixel_valid) begin
            check("first_valid_timeout", 0, 1);
            return;
        end
        check("first_valid_phase", kcyc % FT, 1);
        check("first_valid_within_period", waited <= FT + 2, 1);
        check("busy_in_stream", frame_busy, 1);
        while (!done && cyc < 400) begin
            if (stalled && !(pixel_valid && pixel_color == sc &&
                             pixel_last == sl)) bad_st++;
            pixel_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            stalled = pixel_valid && !pixel_ready;
            sc = pixel_color; sl = pixel_last;
            if (pixel_valid && pixel_ready) begin
                got_c.push_back(pixel_color);
                got_l.push_back(pixel_last);
                if (pixel_last) done = 1;
            end
            @(negedge clk); cyc++;
        end
        pixel_ready = 1'b0;
        check("stream_completed", done, 1);
        check("pixel_count", got_c.size(), exp_q.size());
        for (int i = 0; i < got_c.size() && i < exp_q.size(); i++) begin
            check($sformatf("pix%0d_color", i), got_c[i], exp_q[i]);
            check($sformatf("pix%0d_last", i), got_l[i],
                  i == exp_q.size() - 1);
        end
        check("stall_stable", bad_st, 0);
        check("valid_drop_after_last", pixel_valid, 0);
        check("latch_req_up", latch_req, 1);
        for (int j = 0; j <= ld; j++) begin
            latch_done = (j == ld);
            if (kcyc % FT == FT - 1) g_t++;
            if (frame_overrun) g_p++;
            if (!latch_req) bad_l++;
            @(negedge clk);
        end
        latch_done = 1'b0;
        check("latch_req_held", bad_l, 0);
        check("latch_req_drop", latch_req, 0);
        check("overrun_vs_ticks", g_p, g_t);
    endtask

    task automatic run_empty();
        int w = 0, bad = 0;
        while (kcyc % FT != FT - 1 && w < 200) begin
            @(negedge clk); w++;
        end
        check("empty_tick_seen", kcyc % FT, FT - 1);
        @(negedge clk);
        check("empty_load_busy", frame_busy, 1);
        repeat (8) begin
            if (pixel_valid || latch_req) bad++;
            @(negedge clk);
        end
        check("empty_back_to_wait", frame_busy, 0);
        check("empty_no_pixels", bad, 0);
    endtask

    task automatic do_frame(input int lvl, n, z0, z1, hf, mode, ld,
                            input grb_t a, b, cc);
        apply(lvl, n, z0, z1, hf, a, b, cc);
        model_frame(n, z0, z1, hf, a, b, cc);
        if (n > 0) run_frame(mode, ld);
        else run_empty();
        check("on_count", on_count, m_on);
        check("peak_pos", peak_pos, m_peak);
    endtask

    typedef struct {
        int lvl, n, z0, z1, hf, mode, ld, exp_on, exp_peak;
    } vec_t;
    vec_t tbl[11];

    localparam grb_t CA = 24'h110000, CB = 24'h002200, CC = 24'h000033;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{5, 8, 3, 5, 0, 0, 2, 5, 5};
        tbl[1]  = '{6, 8, 3, 5, 2, 1, 1, 6, 6};
        tbl[2]  = '{2, 8, 3, 5, 2, 1, 0, 2, 6};
        tbl[3]  = '{2, 8, 3, 5, 2, 0, 3, 2, 6};
        tbl[4]  = '{2, 8, 3, 5, 2, 1, 1, 2, 5};
        tbl[5]  = '{2, 8, 3, 5, 2, 1, 1, 2, 4};
        tbl[6]  = '{2, 8, 3, 5, 2, 0, 1, 2, 3};
        tbl[7]  = '{20, 8, 3, 5, 2, 1, 2, 8, 8};
        tbl[8]  = '{3, 0, 3, 5, 2, 0, 0, 0, 0};
        tbl[9]  = '{3, 8, 6, 2, 2, 1, 1, 3, 3};
        tbl[10] = '{0, 4, 3, 5, 2, 0, 1, 0, 3};

        repeat (3) @(negedge clk);
        check("rst_level_ready", level_ready, 0);
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_latch_req", latch_req, 0);
        check("rst_frame_busy", frame_busy, 0);
        check("rst_on_count", on_count, 0);
        check("rst_peak_pos", peak_pos, 0);
        reset = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        check("level_ready_after_reset", level_ready, 1);

        foreach (tbl[i]) begin
            do_frame(tbl[i].lvl, tbl[i].n, tbl[i].z0, tbl[i].z1,
                     tbl[i].hf, tbl[i].mode, tbl[i].ld, CA, CB, CC);
            check($sformatf("tbl%0d_on", i), on_count, tbl[i].exp_on);
            check($sformatf("tbl%0d_peak", i), peak_pos, tbl[i].exp_peak);
        end

        // latch_done withheld for two frame periods
        do_frame(5, 8, 3, 5, 2, 0, 2 * FT, CA, CB, CC);
        check("overrun_two_ticks", g_t >= 2, 1);
        do_frame(5, 8, 3, 5, 2, 1, 1, CA, CB, CC);

        // reset while streaming index 4
        begin
            int w = 0, cnt = 0;
            apply(4, 8, 3, 5, 2, CA, CB, CC);
            pixel_ready = 1'b1;
            while (!(pixel_valid && cnt == 4) && w < 300) begin
                if (pixel_valid && pixel_ready) cnt++;
                @(negedge clk); w++;
            end
            check("reached_index4", cnt, 4);
            reset = 1'b1;
            pixel_ready = 1'b0;
            @(negedge clk);
            check("mid_rst_valid", pixel_valid, 0);
            check("mid_rst_color", pixel_color, 0);
            check("mid_rst_last", pixel_last, 0);
            check("mid_rst_latch", latch_req, 0);
            check("mid_rst_busy", frame_busy, 0);
            check("mid_rst_overrun", frame_overrun, 0);
            check("mid_rst_on", on_count, 0);
            check("mid_rst_peak", peak_pos, 0);
            check("mid_rst_lready", level_ready, 0);
            reset = 1'b0;
            m_level = 0; m_peak = 0; m_hold = 0;
            @(negedge clk);
            do_frame(4, 8, 3, 5, 2, 0, 1, CA, CB, CC);
        end

        for (int r = 0; r < 20; r++) begin
            do_frame(int'($urandom_range(0, 12)),
                     int'($urandom_range(0, 10)),
                     int'($urandom_range(0, 10)),
                     int'($urandom_range(0, 10)),
                     int'($urandom_range(0, 3)), 1,
                     int'($urandom_range(0, 5)),
                     24'($urandom), 24'($urandom), 24'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ws2812b_meter_scheduler.md
Name: ws2812b_meter_scheduler

Overview:
Frame-level controller that sits in front of the WS2812B pixel serializer.
- Accepts level samples, runs peak-hold/decay, and on every frame tick streams exactly led_count 24-bit GRB pixel words over a valid/ready handshake.
- After the last pixel, requests a latch (reset gap) from the serializer and waits for completion.
- It sequences the serializer; it does no bit timing itself.

Parameters:
FRAME_TICKS, 1666667, clk cycles per frame period (60 Hz at 100 MHz); counter width 24 bits, legal 8..2^24-1.
PEAK_COLOR, 24'hFFFFFF, GRB word sent for the peak-marker LED.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  frames start only while high
level_valid  in  1  level sample strobe
level_ready  out  1  high whenever reset is low (samples never stall)
level  in  16  lit-LED request; clamped to led_count
led_count  in  16  total LEDs in the strip; sampled at frame start
zone_limit0  in  16  indices < zone_limit0 use color0
zone_limit1  in  16  indices in [zone_limit0, zone_limit1) use color1; all others use color2
color0, color1, color2  in  24 each  zone GRB colors
peak_hold_frames  in  8  frames the peak holds before it decays
pixel_valid  out  1  pixel word offered
pixel_ready  in  1  serializer accepts the word
pixel_color  out  24  GRB word
pixel_last  out  1  high with the final pixel of a frame
latch_req  out  1  request for a >50 us reset gap
latch_done  in  1  one-cycle pulse when the gap has been sent
frame_busy  out  1  high in LOAD/STREAM/LATCH
frame_overrun  out  1  one-cycle pulse when a tick falls while frame_busy
on_count  out  16  lit count of the current frame
peak_pos  out  16  current peak position

Behaviour:
- Reset values: every output 0 except level_ready (0 during reset, 1 after). Internal state: tick counter 0, latched level 0, peak 0, hold 0, state IDLE.
- Level input: the sample is registered on level_valid. The newest sample wins. The sample is held until the next one arrives.
- Tick counter: free-running from 0 to FRAME_TICKS-1, then wraps to 0. It runs regardless of state. A tick is the cycle in which the counter equals FRAME_TICKS-1.
- IDLE: move to WAIT on the first cycle that enable=1.
- WAIT:
  - tick and enable=1 -> LOAD.
  - enable=0 -> IDLE.
- LOAD, one cycle:
  - snapshot n = led_count;
  - on = min(level, n);
  - update peak (rules below);
  - pixel index = 0.
  - If n == 0, go straight to WAIT: no pixels, no latch.
  - Otherwise go to STREAM.
- Peak update:
  - if on >= peak: peak = on, hold = peak_hold_frames;
  - else if hold > 0: hold -= 1;
  - else if peak > 0: peak -= 1.
  - Then clamp peak to n.
- STREAM:
  - pixel_valid is high from the first STREAM cycle, which is 2 cycles after the tick.
  - On each handshake (valid and ready), the index increments.
  - pixel_color, pixel_last and pixel_valid stay stable while valid=1 and ready=0.
  - Color for index i:
    - i < on: zone color chosen by zone_limit0/zone_limit1;
    - else if peak > on and i == peak-1: PEAK_COLOR;
    - else 24'h000000.
  - pixel_last = (i == n-1).
  - A handshake on the last pixel deasserts pixel_valid on the next cycle and moves to LATCH.
  - Back-to-back handshakes sustain one pixel per cycle.
- LATCH: latch_req is held high until a cycle with latch_done=1. latch_req drops on the next cycle and the state returns to WAIT. A latch_done seen outside LATCH is ignored.
- Inputs changed mid-frame: enable, zone_limit*, colors and led_count are not re-sampled. The frame always completes exactly n pixels and one latch. Zone limits and colors are used combinationally per pixel, and software must keep them stable during a frame.
- Overrun: a tick while frame_busy pulses frame_overrun and is dropped. The next frame starts on the first tick after the state reaches WAIT.
- Zone limits: if zone_limit1 <= zone_limit0, the color1 zone is empty.
- Widths: comparisons are 16-bit unsigned. No value wraps: on <= n, and peak <= n after clamping.
- Reset: reset asserted mid-STREAM or mid-LATCH drops pixel_valid and latch_req on the next edge. All state returns to reset values.

Decomposition:
- Package ws2812b_meter_pkg: 24-bit GRB color type, COLOR_OFF constant, scheduler state enum (IDLE, WAIT, LOAD, STREAM, LATCH), reset-gap timing constants shared with the serializer.
- Sub-module ws2812b_peak_hold: peak/hold registers and the update rule, enabled by a one-cycle load strobe.

Test Plan:
- FRAME_TICKS=64, led_count=8, level=5, zone limits 3/5, serializer always ready:
  - pixels 0-2 = color0, 3-4 = color1, 5-7 = 0;
  - pixel_last on index 7;
  - first pixel_valid 2 cycles after the tick;
  - latch_req follows.
- pixel_ready toggled randomly: no pixel lost or duplicated; pixel_color stable while stalled; exactly 8 words per frame.
- Peak with peak_hold_frames=2:
  - level 6 then 2 over successive frames;
  - peak_pos holds 6 for 2 frames, then reads 5, 4, 3;
  - index 5 = PEAK_COLOR on the frames where peak=6 (index = peak_pos-1 after each decay).
- level=20, led_count=8: on_count=8, all pixels lit, no peak marker. led_count=0: no pixel_valid, no latch_req, returns to WAIT.
- latch_done held off for 2 frame periods: frame_overrun pulses at each tick; the next frame starts on the first tick after latch_done.
- Reset asserted while pixel_valid=1 at index 4: the next cycle has all outputs 0 and the state is IDLE. After release, the first frame starts from index 0 with peak 0.
